vga_text_renderer: RTL and testbench
====================================

Name: vga_text_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing controller.
- Consumes X/Y coordinates and raw HS/VS/BLANK_N from the controller; outputs aligned sync and 24-bit RGB for the DAC.
- Renders an 80x30 text console: external character RAM plus external 8x16 font ROM, both synchronous with 1-cycle read latency, and a 16-colour CGA palette.
- Pipelined so that RGB and syncs leave the block on the same cycle.

Parameters:
- COLS, 80, characters per row; column index = X[9:3].
- ROWS, 30, character rows; row index = Y[8:4].
- BLINK_FRAMES, 30, frames per cursor blink half-period.

Ports:
- Clk  in  1  pixel clock, 25 MHz; top level drives it from the controller's VGA_CLK.
- Reset  in  1  asynchronous, active-high.
- X  in  10  horizontal pixel coordinate from the controller.
- Y  in  10  vertical pixel coordinate from the controller.
- hs_in  in  1  raw horizontal sync, active low.
- vs_in  in  1  raw vertical sync, active low.
- blank_n_in  in  1  raw display-enable, active low blank.
- vram_addr  out  12  character RAM address = row*COLS + col (0..2399).
- vram_data  in  16  [7:0] char code, [11:8] fg colour, [15:12] bg colour; valid 1 cycle after vram_addr.
- font_addr  out  12  {char code, glyph row Y[3:0]}.
- font_data  in  8  glyph row; bit 7 = leftmost pixel; valid 1 cycle after font_addr.
- cursor_col  in  7  cursor column.
- cursor_row  in  5  cursor row.
- cursor_on  in  1  cursor enable.
- VGA_HS  out  1  aligned horizontal sync.
- VGA_VS  out  1  aligned vertical sync.
- VGA_BLANK_N  out  1  aligned blank.
- VGA_R  out  8  red.
- VGA_G  out  8  green.
- VGA_B  out  8  blue.

Behaviour:
- Pipeline, pixel presented on X/Y at cycle t:
  - t: vram_addr driven combinationally from X/Y; Y[3:0] and X[2:0] enter the delay line.
  - t+1: font_addr driven combinationally from vram_data[7:0] and the 1-cycle-delayed Y[3:0]; vram_data[15:8] registered.
  - t+2: pixel bit = font_data[7 - X[2:0] delayed 2]; colour index = bit ? fg : bg.
  - t+3: VGA_R/G/B registered from the palette.
- Total latency is exactly 3 cycles. hs_in, vs_in and blank_n_in pass through a 3-stage register chain so they align with RGB.
- Blanking: if the delayed blank_n is 0, RGB = 0 regardless of glyph data.
- Pixels with Y >= 480 or X >= 640 are always blanked by blank_n_in. vram_addr and font_addr values in that region are don't-care but must stay within 0..4095 without X-propagation.
- Address arithmetic: row (5 bits) * 80 + col (7 bits), computed at 12-bit width; no wrap inside the visible region.
- Palette (index: hex RRGGBB):
  - 0: 000000, 1: 0000AA, 2: 00AA00, 3: 00AAAA
  - 4: AA0000, 5: AA00AA, 6: AA5500, 7: AAAAAA
  - 8: 555555, 9: 5555FF, 10: 55FF55, 11: 55FFFF
  - 12: FF5555, 13: FF55FF, 14: FFFF55, 15: FFFFFF
- Reset (async, any time):
  - All pipeline registers clear.
  - RGB = 0, VGA_BLANK_N = 0, VGA_HS = 1, VGA_VS = 1.
  - Blink counter = 0, blink phase = visible.
  - The first valid RGB appears 3 cycles after Reset deasserts.

Optional Feature:
- Macro: TEXT_CURSOR_EN.
- Defined:
  - Frame counter increments once per frame, on the cycle X==0 && Y==0 enters stage 0.
  - On reaching BLINK_FRAMES-1 the counter wraps to 0 and the blink phase toggles.
  - When cursor_on=1, phase = visible, and the pixel's delayed cell matches (cursor_col, cursor_row), glyph rows 14 and 15 force fg colour for all 8 pixels (underline cursor).
  - Cursor coordinates are sampled at stage 0 and delayed with the pixel.
  - cursor_on=0 hides the cursor immediately; the counter keeps running.
- Undefined: no cursor logic or counter; cursor_* inputs are ignored.

Test Plan:
- Reset mid-frame with X=100, Y=50 -> next cycle RGB=0, BLANK_N=0, HS=VS=1. After release, BLANK_N first follows blank_n_in delayed by 3 cycles.
- X=0, Y=0; vram_data=0x1F41 ('A', fg 15, bg 1); font_data=0x80 -> vram_addr=0, font_addr=0x410. At t+3 RGB=FFFFFF; pixel X=1 of the same cell gives 0000AA.
- X=639, Y=479 -> vram_addr=2399, font_addr low nibble=0xF. Alignment checked: hs_in/blank_n_in edges reach outputs exactly 3 cycles later.
- blank_n_in=0 with font_data=0xFF and fg=15 -> RGB=000000 for the 3-cycle-delayed pixels.
- vram_data colour sweep 0..15, all-ones glyph -> RGB matches the palette table for each index.
- TEXT_CURSOR_EN defined, BLINK_FRAMES=2, cursor at (3,2), cursor_on=1, blank glyph fg=14 bg=0:
  - Frames 0-1: Y=46..47, X=24..31 -> FFFF55.
  - Frames 2-3: same pixels -> 000000.
  - Y=45 in any frame -> 000000.

Source files
------------

// File: rtl/vga_text_renderer.sv
// Text-mode pixel stage: 80x30 character cells, 8x16 glyphs and a 16-colour palette.
// The pipeline takes three cycles from X/Y to RGB and syncs. Define TEXT_CURSOR_EN to add a blinking underline cursor.
module vga_text_renderer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  X,
    input  logic [9:0]  Y,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_n_in,
    output logic [11:0] vram_addr,
    input  logic [15:0] vram_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_on,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    function automatic logic [23:0] palette(input logic [3:0] idx);
        case (idx)
            4'd0:    palette = 24'h000000;
            4'd1:    palette = 24'h0000AA;
            4'd2:    palette = 24'h00AA00;
            4'd3:    palette = 24'h00AAAA;
            4'd4:    palette = 24'hAA0000;
            4'd5:    palette = 24'hAA00AA;
            4'd6:    palette = 24'hAA5500;
            4'd7:    palette = 24'hAAAAAA;
            4'd8:    palette = 24'h555555;
            4'd9:    palette = 24'h5555FF;
            4'd10:   palette = 24'h55FF55;
            4'd11:   palette = 24'h55FFFF;
            4'd12:   palette = 24'hFF5555;
            4'd13:   palette = 24'hFF55FF;
            4'd14:   palette = 24'hFFFF55;
            4'd15:   palette = 24'hFFFFFF;
            default: palette = 24'h000000;
        endcase
    endfunction

    logic [4:0]  row_s;
    logic [6:0]  col_s;
    logic [11:0] addr_calc_s;
    logic        cur_hit_s;
    logic        pix_bit_s;
    logic [3:0]  colour_idx_s;
    logic [23:0] rgb_s;

    logic [3:0]  y_lo_d1_r;
    logic [2:0]  x_lo_d1_r;
    logic [2:0]  x_lo_d2_r;
    logic [7:0]  colour_d2_r;
    logic        hs_d1_r, hs_d2_r;
    logic        vs_d1_r, vs_d2_r;
    logic        bn_d1_r, bn_d2_r;
    logic        cur_d1_r, cur_d2_r;

    assign row_s = Y[8:4];
    assign col_s = X[9:3];

    // Character cell address; outside the 80x30 grid the address is parked at 0.
    always_comb begin
        addr_calc_s = 12'(row_s) * 12'(COLS) + 12'(col_s);
        if ((row_s < 5'(ROWS)) && (col_s < 7'(COLS))) begin
            vram_addr = addr_calc_s;
        end else begin
            vram_addr = 12'd0;
        end
    end

    assign font_addr = {vram_data[7:0], y_lo_d1_r};

`ifdef TEXT_CURSOR_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] frame_cnt_r;
    logic             blink_visible_r;

    // Frame counter and blink phase, stepped when the origin pixel enters the pipe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cnt_r     <= {CNT_W{1'b0}};
            blink_visible_r <= 1'b1;
        end else if ((X == 10'd0) && (Y == 10'd0)) begin
            if (frame_cnt_r == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_r     <= {CNT_W{1'b0}};
                blink_visible_r <= ~blink_visible_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end
        end
    end

    // Underline occupies glyph rows 14 and 15 of the cursor cell.
    assign cur_hit_s = cursor_on && blink_visible_r && (cursor_col == col_s) &&
                       (cursor_row == row_s) && (Y[3:1] == 3'b111);
`else
    logic unused_s;
    assign unused_s  = ^{Y[9], cursor_col, cursor_row, cursor_on};
    assign cur_hit_s = 1'b0;
`endif

    // Glyph bit selection and palette lookup for the pixel now at stage 2.
    always_comb begin
        pix_bit_s = font_data[3'd7 - x_lo_d2_r];
        if (pix_bit_s || cur_d2_r) begin
            colour_idx_s = colour_d2_r[3:0];
        end else begin
            colour_idx_s = colour_d2_r[7:4];
        end
        rgb_s = palette(colour_idx_s);
    end

    // Delay line; syncs rest at their inactive high level during reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            y_lo_d1_r   <= 4'd0;
            x_lo_d1_r   <= 3'd0;
            x_lo_d2_r   <= 3'd0;
            colour_d2_r <= 8'd0;
            hs_d1_r     <= 1'b1;
            hs_d2_r     <= 1'b1;
            vs_d1_r     <= 1'b1;
            vs_d2_r     <= 1'b1;
            bn_d1_r     <= 1'b0;
            bn_d2_r     <= 1'b0;
            cur_d1_r    <= 1'b0;
            cur_d2_r    <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'd0;
            VGA_G       <= 8'd0;
            VGA_B       <= 8'd0;
        end else begin
            y_lo_d1_r   <= Y[3:0];
            x_lo_d1_r   <= X[2:0];
            x_lo_d2_r   <= x_lo_d1_r;
            colour_d2_r <= vram_data[15:8];
            hs_d1_r     <= hs_in;
            hs_d2_r     <= hs_d1_r;
            vs_d1_r     <= vs_in;
            vs_d2_r     <= vs_d1_r;
            bn_d1_r     <= blank_n_in;
            bn_d2_r     <= bn_d1_r;
            cur_d1_r    <= cur_hit_s;
            cur_d2_r    <= cur_d1_r;
            VGA_HS      <= hs_d2_r;
            VGA_VS      <= vs_d2_r;
            VGA_BLANK_N <= bn_d2_r;
            if (bn_d2_r) begin
                VGA_R <= rgb_s[23:16];
                VGA_G <= rgb_s[15:8];
                VGA_B <= rgb_s[7:0];
            end else begin
                VGA_R <= 8'd0;
                VGA_G <= 8'd0;
                VGA_B <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: table vectors, reset sequences, random pixels against a reference model,
// and a cursor blink sequence (expected values depend on TEXT_CURSOR_EN).
module tb_vga_text_renderer;

    localparam int BF = 2;
`ifdef TEXT_CURSOR_EN
    localparam bit CUR = 1'b1;
`else
    localparam bit CUR = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  X, Y;
    logic        hs_in, vs_in, blank_n_in;
    logic [11:0] vram_addr, font_addr;
    logic [15:0] vram_data;
    logic [7:0]  font_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        cursor_on;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    vga_text_renderer #(.COLS(80), .ROWS(30), .BLINK_FRAMES(BF)) dut (
        .Clk(Clk), .Reset(Reset), .X(X), .Y(Y),
        .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
        .vram_addr(vram_addr), .vram_data(vram_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_on(cursor_on),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #20 Clk = ~Clk;

    logic [15:0] vram_mem [4096];
    logic [7:0]  font_mem [4096];
    logic [23:0] pal [16];

    // Synchronous RAM/ROM with one cycle of read latency.
    always @(posedge Clk) begin
        vram_data <= vram_mem[vram_addr];
        font_data <= font_mem[font_addr];
    end

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bn;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] vd;
        logic [7:0]  fd;
        logic        bn;
        logic [11:0] va;
        logic [11:0] fa;
        logic [23:0] rgb;
    } vec_t;

    exp_t        q[$];
    vec_t        tv[$];
    int          total = 0;
    int          bad = 0;
    int          starts = 0;
    bit          pend_fchk = 1'b0;
    logic [11:0] pend_fexp = 12'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference: cell lookup, glyph bit, palette, plus the underline cursor rule.
    function automatic logic [23:0] model_rgb(input int x, input int y, input logic bn,
                                              input int ccol, input int crow, input logic con,
                                              input int sb);
        logic [15:0] d;
        logic [7:0]  g;
        logic [3:0]  idx;
        if (!bn) return 24'h000000;
        d   = vram_mem[(y / 16) * 80 + x / 8];
        g   = font_mem[int'(d[7:0]) * 16 + y % 16];
        idx = g[7 - x % 8] ? d[11:8] : d[15:12];
        if (CUR && con && ((sb / BF) % 2 == 0) && (x / 8 == ccol) && (y / 16 == crow) && (y % 16 >= 14))
            idx = d[11:8];
        return pal[idx];
    endfunction

    task automatic step(input int x, input int y, input logic hs, input logic vs, input logic bn,
                        input int ccol, input int crow, input logic con,
                        input bit ovr, input logic [23:0] ovr_rgb,
                        input bit vchk, input logic [11:0] vexp,
                        input bit fchk, input logic [11:0] fexp);
        exp_t e;
        @(negedge Clk);
        if (pend_fchk) chk("font_addr", 32'(font_addr), 32'(pend_fexp));
        if (q.size() >= 3) begin
            e = q.pop_front();
            chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e.rgb));
            chk("hs_vs_blank", 32'({VGA_HS, VGA_VS, VGA_BLANK_N}), 32'({e.hs, e.vs, e.bn}));
        end
        Reset      = 1'b0;
        X          = 10'(x);
        Y          = 10'(y);
        hs_in      = hs;
        vs_in      = vs;
        blank_n_in = bn;
        cursor_col = 7'(ccol);
        cursor_row = 5'(crow);
        cursor_on  = con;
        e.rgb = ovr ? ovr_rgb : model_rgb(x, y, bn, ccol, crow, con, starts);
        e.hs  = hs;
        e.vs  = vs;
        e.bn  = bn;
        q.push_back(e);
        if (x == 0 && y == 0) starts++;
        pend_fchk = fchk;
        pend_fexp = fexp;
        if (vchk) begin
            #1;
            chk("vram_addr", 32'(vram_addr), 32'(vexp));
        end
    endtask

    task automatic idle();
        step(700, 500, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 24'h0, 1'b0, 12'd0, 1'b0, 12'd0);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge Clk);
        #5 Reset = 1'b1;
        #1;
        chk("reset_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        chk("reset_hs_vs_blank", 32'({VGA_HS, VGA_VS, VGA_BLANK_N}), 32'({1'b1, 1'b1, 1'b0}));
        @(posedge Clk);
        q.delete();
        e.rgb = 24'h0; e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
        q.push_back(e);
        q.push_back(e);
        starts    = 0;
        pend_fchk = 1'b0;
    endtask

    initial begin
        vec_t        v;
        int          x, y, ccol, crow;
        logic        bn, con;
        logic [11:0] va, fa;
        logic [23:0] want;

        pal = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
        for (int i = 0; i < 4096; i++) begin
            vram_mem[i] = 16'($urandom);
            font_mem[i] = 8'($urandom);
        end
        Reset = 1'b0; X = 10'd0; Y = 10'd0; hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b0;
        cursor_col = 7'd0; cursor_row = 5'd0; cursor_on = 1'b0;

        tv.push_back('{0,   0,   16'h1F41, 8'h80, 1'b1, 12'd0,    12'h410, 24'hFFFFFF});
        tv.push_back('{1,   0,   16'h1F41, 8'h80, 1'b1, 12'd0,    12'h410, 24'h0000AA});
        tv.push_back('{639, 479, 16'h4A33, 8'h01, 1'b1, 12'd2399, 12'h33F, 24'h55FF55});
        tv.push_back('{8,   16,  16'h0F22, 8'hFF, 1'b0, 12'd81,   12'h220, 24'h000000});
        for (int i = 0; i < 16; i++) begin
            v.x = 16 + i * 8; v.y = 32;
            v.vd = {4'(15 - i), 4'(i), 8'(8'h40 + i)};
            v.fd = 8'hFF; v.bn = 1'b1;
            v.va = 12'(162 + i);
            v.fa = {8'(8'h40 + i), 4'h0};
            v.rgb = pal[i];
            tv.push_back(v);
        end

        do_reset();
        foreach (tv[i]) begin
            vram_mem[tv[i].va] = tv[i].vd;
            font_mem[tv[i].fa] = tv[i].fd;
            step(tv[i].x, tv[i].y, 1'b1, 1'b1, tv[i].bn, 0, 0, 1'b0,
                 1'b1, tv[i].rgb, 1'b1, tv[i].va, 1'b1, tv[i].fa);
            idle();
            idle();
        end

        // Reset in the middle of a frame with active syncs and visible pixels.
        for (int i = 0; i < 4; i++)
            step(100, 50, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 24'h0, 1'b0, 12'd0, 1'b0, 12'd0);
        do_reset();

        for (int n = 0; n < 600; n++) begin
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 524);
            if (x < 640 && y < 480) bn = ($urandom_range(0, 7) != 0);
            else bn = 1'b0;
            ccol = $urandom_range(0, 79);
            crow = $urandom_range(0, 29);
            con  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0 && x < 640 && y < 480) begin
                ccol = x / 8;
                crow = y / 16;
            end
            if (x < 640 && y < 480) begin
                va = 12'((y / 16) * 80 + x / 8);
                fa = {vram_mem[va][7:0], 4'(y % 16)};
                step(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bn, ccol, crow, con,
                     1'b0, 24'h0, 1'b1, va, 1'b1, fa);
            end else begin
                step(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bn, ccol, crow, con,
                     1'b0, 24'h0, 1'b0, 12'd0, 1'b0, 12'd0);
            end
        end

        // Cursor at (3,2), blank glyph, fg 14 on bg 0, across four frames.
        do_reset();
        vram_mem[163] = 16'h0E20;
        for (int r = 0; r < 16; r++) font_mem[12'h200 + r] = 8'h00;
        for (int f = 0; f < 4; f++) begin
            if (f > 0)
                step(0, 0, 1'b1, 1'b1, 1'b1, 3, 2, 1'b1, 1'b0, 24'h0, 1'b0, 12'd0, 1'b0, 12'd0);
            for (int yy = 45; yy <= 47; yy++) begin
                for (int xx = 24; xx <= 31; xx++) begin
                    want = (CUR && yy >= 46 && f < 2) ? 24'hFFFF55 : 24'h000000;
                    step(xx, yy, 1'b1, 1'b1, 1'b1, 3, 2, 1'b1, 1'b1, want, 1'b1, 12'd163, 1'b0, 12'd0);
                end
            end
        end
        for (int i = 0; i < 4; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
